// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: redirect input, instruction-memory req/ack and decode valid/ready.
interface fetch_pc_unit_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = 32
);
  logic              switch_branch;
  logic [ADDR_W-1:0] branch_target;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst_out;
  logic [ADDR_W-1:0] pc_out;
  logic              flush;
  logic              misalign_err;

  // Fetch unit side.
  modport master (
    input  switch_branch, branch_target, imem_ack, imem_rdata, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_out, pc_out, flush, misalign_err
  );

  // Environment side: branch control, instruction memory and decode.
  modport slave (
    output switch_branch, branch_target, imem_ack, imem_rdata, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_out, pc_out, flush, misalign_err
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch stage. Issues one word fetch at a time,
// hands each instruction to decode, and redirects on taken branches.
module fetch_pc_unit #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  fetch_pc_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_DEC = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] req_addr;
  logic              imem_req_q;
  logic              inst_valid_q;
  logic [INST_W-1:0] inst_out_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic              flush_q;
  logic              misalign_q;

  // Redirect target with the low bits forced to a word boundary.
  logic [ADDR_W-1:0] target_aligned_c;
  logic              target_misaligned_c;
  logic [ADDR_W-1:0] pc_next_seq_c;

  assign target_aligned_c    = {bus.branch_target[ADDR_W-1:2], 2'b00};
  assign target_misaligned_c = |bus.branch_target[1:0];
  assign pc_next_seq_c       = pc + ADDR_W'(4);

  // Fetch state machine; a redirect overrides every non-reset event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      req_addr     <= RESET_PC;
      imem_req_q   <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      pc_out_q     <= '0;
      flush_q      <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      if (bus.switch_branch) begin
        pc           <= target_aligned_c;
        flush_q      <= 1'b1;
        inst_valid_q <= 1'b0;
        if (target_misaligned_c) begin
          misalign_q <= 1'b1;
        end
        case (state)
          FETCH, DRAIN: begin
            // An outstanding request cannot be withdrawn; wait out its ack.
            if (bus.imem_ack) begin
              state      <= FETCH;
              req_addr   <= target_aligned_c;
              imem_req_q <= 1'b1;
            end else begin
              state      <= DRAIN;
              imem_req_q <= 1'b1;
            end
          end
          default: begin
            state      <= FETCH;
            req_addr   <= target_aligned_c;
            imem_req_q <= 1'b1;
          end
        endcase
      end else begin
        case (state)
          IDLE: begin
            state      <= FETCH;
            req_addr   <= pc;
            imem_req_q <= 1'b1;
          end
          FETCH: begin
            if (bus.imem_ack) begin
              state        <= WAIT_DEC;
              inst_out_q   <= bus.imem_rdata;
              pc_out_q     <= req_addr;
              inst_valid_q <= 1'b1;
              pc           <= pc_next_seq_c;
              imem_req_q   <= 1'b0;
            end
          end
          WAIT_DEC: begin
            if (bus.inst_ready) begin
              state        <= FETCH;
              inst_valid_q <= 1'b0;
              req_addr     <= pc;
              imem_req_q   <= 1'b1;
            end
          end
          DRAIN: begin
            // Stale data from the pre-redirect request is dropped here.
            if (bus.imem_ack) begin
              state      <= FETCH;
              req_addr   <= pc;
              imem_req_q <= 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            imem_req_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.imem_req     = imem_req_q;
  assign bus.imem_addr    = req_addr;
  assign bus.inst_valid   = inst_valid_q;
  assign bus.inst_out     = inst_out_q;
  assign bus.pc_out       = pc_out_q;
  assign bus.flush        = flush_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, decode stall, redirects,
// drain, misaligned target, mid-request reset and PC wrap-around.
module tb_fetch_pc_unit;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned INST_W = 32;
  localparam logic [ADDR_W-1:0] TOP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic clk;
  logic reset_a;
  logic reset_b;
  int   checks;
  int   errors;

  fetch_pc_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus_a ();
  fetch_pc_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus_b ();

  fetch_pc_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC('0)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a.master)
  );

  fetch_pc_unit #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(TOP_PC)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_a = 1'b0;
    reset_b = 1'b0;
    bus_a.switch_branch = 1'b0;
    bus_a.branch_target = '0;
    bus_a.imem_ack      = 1'b0;
    bus_a.imem_rdata    = '0;
    bus_a.inst_ready    = 1'b0;
    bus_b.switch_branch = 1'b0;
    bus_b.branch_target = '0;
    bus_b.imem_ack      = 1'b0;
    bus_b.imem_rdata    = '0;
    bus_b.inst_ready    = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_req",   64'(bus_a.imem_req), 64'd0);
    check("rst_valid", 64'(bus_a.inst_valid), 64'd0);
    check("rst_flush", 64'(bus_a.flush), 64'd0);
    check("rst_err",   64'(bus_a.misalign_err), 64'd0);
    check("rst_inst",  64'(bus_a.inst_out), 64'd0);
    check("rst_pcout", bus_a.pc_out, 64'd0);
    check("rst_addr",  bus_a.imem_addr, 64'd0);

    // IDLE -> FETCH at RESET_PC.
    reset_a = 1'b1;
    tick();
    check("f0_req",  64'(bus_a.imem_req), 64'd1);
    check("f0_addr", bus_a.imem_addr, 64'd0);

    // Sequential fetch 0,4,8 with single-cycle ack and decode always ready.
    bus_a.inst_ready = 1'b1;
    bus_a.imem_rdata = 32'h0000_0013;
    for (int i = 0; i < 3; i++) begin
      bus_a.imem_ack = 1'b1;
      tick();
      check("seq_valid", 64'(bus_a.inst_valid), 64'd1);
      check("seq_pcout", bus_a.pc_out, 64'(4 * i));
      check("seq_inst",  64'(bus_a.inst_out), 64'h13);
      check("seq_noreq", 64'(bus_a.imem_req), 64'd0);
      if (i < 2) begin
        bus_a.imem_ack = 1'b0;
        tick();
        check("seq_gap_valid", 64'(bus_a.inst_valid), 64'd0);
        check("seq_addr", bus_a.imem_addr, 64'(4 * (i + 1)));
      end
    end

    // Decode stall: outputs hold, no new request.
    bus_a.imem_ack   = 1'b0;
    bus_a.inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 64'(bus_a.inst_valid), 64'd1);
      check("stall_pcout", bus_a.pc_out, 64'h8);
      check("stall_inst",  64'(bus_a.inst_out), 64'h13);
      check("stall_req",   64'(bus_a.imem_req), 64'd0);
    end

    // Redirect from WAIT_DEC with inst_ready high: held instruction dropped.
    bus_a.switch_branch = 1'b1;
    bus_a.branch_target = 64'h100;
    bus_a.inst_ready    = 1'b1;
    tick();
    check("rd1_flush", 64'(bus_a.flush), 64'd1);
    check("rd1_valid", 64'(bus_a.inst_valid), 64'd0);
    check("rd1_req",   64'(bus_a.imem_req), 64'd1);
    check("rd1_addr",  bus_a.imem_addr, 64'h100);
    bus_a.switch_branch = 1'b0;
    tick();
    check("rd1_flush_off", 64'(bus_a.flush), 64'd0);
    check("rd1_addr_hold", bus_a.imem_addr, 64'h100);
    check("rd1_no_valid",  64'(bus_a.inst_valid), 64'd0);

    // Complete the fetch at 0x100.
    bus_a.imem_ack   = 1'b1;
    bus_a.imem_rdata = 32'hAAAA_0001;
    tick();
    check("f100_valid", 64'(bus_a.inst_valid), 64'd1);
    check("f100_pcout", bus_a.pc_out, 64'h100);
    check("f100_inst",  64'(bus_a.inst_out), 64'hAAAA_0001);
    bus_a.imem_ack = 1'b0;
    tick();
    check("f104_addr", bus_a.imem_addr, 64'h104);

    // Redirect on the first FETCH cycle without ack -> DRAIN at old address.
    bus_a.switch_branch = 1'b1;
    bus_a.branch_target = 64'h200;
    tick();
    check("dr_flush1", 64'(bus_a.flush), 64'd1);
    check("dr_addr1",  bus_a.imem_addr, 64'h104);
    check("dr_req1",   64'(bus_a.imem_req), 64'd1);
    bus_a.switch_branch = 1'b0;
    tick();
    check("dr_flush_gap", 64'(bus_a.flush), 64'd0);
    check("dr_addr2",     bus_a.imem_addr, 64'h104);
    // Second redirect during DRAIN; last target wins.
    bus_a.switch_branch = 1'b1;
    bus_a.branch_target = 64'h300;
    tick();
    check("dr_flush2", 64'(bus_a.flush), 64'd1);
    check("dr_addr3",  bus_a.imem_addr, 64'h104);
    check("dr_req3",   64'(bus_a.imem_req), 64'd1);
    // Late ack: data discarded, refetch at 0x300.
    bus_a.switch_branch = 1'b0;
    bus_a.imem_ack      = 1'b1;
    bus_a.imem_rdata    = 32'hDEAD_BEEF;
    tick();
    check("dr_done_valid", 64'(bus_a.inst_valid), 64'd0);
    check("dr_done_addr",  bus_a.imem_addr, 64'h300);
    check("dr_done_req",   64'(bus_a.imem_req), 64'd1);
    check("dr_done_flush", 64'(bus_a.flush), 64'd0);
    bus_a.imem_rdata = 32'h0000_0033;
    tick();
    check("f300_valid", 64'(bus_a.inst_valid), 64'd1);
    check("f300_pcout", bus_a.pc_out, 64'h300);
    check("f300_inst",  64'(bus_a.inst_out), 64'h33);

    // Misaligned redirect from WAIT_DEC.
    bus_a.imem_ack      = 1'b0;
    bus_a.inst_ready    = 1'b0;
    bus_a.switch_branch = 1'b1;
    bus_a.branch_target = 64'h102;
    tick();
    check("mis_addr",  bus_a.imem_addr, 64'h100);
    check("mis_err",   64'(bus_a.misalign_err), 64'd1);
    check("mis_flush", 64'(bus_a.flush), 64'd1);
    // Redirect in FETCH coinciding with ack: data dropped, straight to new fetch.
    bus_a.imem_ack      = 1'b1;
    bus_a.branch_target = 64'h400;
    tick();
    check("fa_addr",  bus_a.imem_addr, 64'h400);
    check("fa_valid", 64'(bus_a.inst_valid), 64'd0);
    check("fa_flush", 64'(bus_a.flush), 64'd1);
    check("fa_err",   64'(bus_a.misalign_err), 64'd1);
    bus_a.switch_branch = 1'b0;
    bus_a.imem_ack      = 1'b0;
    tick();
    check("fa_addr_hold", bus_a.imem_addr, 64'h400);
    check("fa_flush_off", 64'(bus_a.flush), 64'd0);
    check("err_sticky",   64'(bus_a.misalign_err), 64'd1);

    // Reset while FETCH awaits ack; ack arrives during reset.
    reset_a          = 1'b0;
    bus_a.imem_ack   = 1'b1;
    bus_a.imem_rdata = 32'h0000_0055;
    tick();
    check("mr_req",   64'(bus_a.imem_req), 64'd0);
    check("mr_valid", 64'(bus_a.inst_valid), 64'd0);
    check("mr_err",   64'(bus_a.misalign_err), 64'd0);
    check("mr_inst",  64'(bus_a.inst_out), 64'd0);
    check("mr_pcout", bus_a.pc_out, 64'd0);
    check("mr_addr",  bus_a.imem_addr, 64'd0);
    bus_a.imem_ack = 1'b0;
    reset_a = 1'b1;
    tick();
    check("mr_fetch_req",  64'(bus_a.imem_req), 64'd1);
    check("mr_fetch_addr", bus_a.imem_addr, 64'd0);

    // PC wrap from the top aligned address.
    reset_b = 1'b1;
    tick();
    check("wrap_addr0", bus_b.imem_addr, TOP_PC);
    bus_b.imem_ack   = 1'b1;
    bus_b.inst_ready = 1'b1;
    bus_b.imem_rdata = 32'h0000_0077;
    tick();
    check("wrap_pcout", bus_b.pc_out, TOP_PC);
    check("wrap_valid", 64'(bus_b.inst_valid), 64'd1);
    bus_b.imem_ack = 1'b0;
    tick();
    check("wrap_addr1", bus_b.imem_addr, 64'd0);
    check("wrap_err",   64'(bus_b.misalign_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
